ahb_lite_sram_responder: RTL and testbench

AHB-Lite responder (slave) with an internal byte-addressable word memory, programmable wait states and AHB two-cycle ERROR responses. It is the far end of the CPU subsystem's AHB-Lite initiator ports (system bus, iahbl, dahbl) and serves as a tightly coupled scratch RAM or as a bench responder. Write byte lanes are little-endian. The byte lane for a byte address with addr[1:0]=n is hwdata/hrdata[8n+7:8n], matching the initiator's read-data lane mux.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_sram_byte_array.sv | 26 ++
 rtl/ahb_lite_sram_responder.sv | 124 ++++++++++++
 tb/tb_ahb_lite_sram_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM state type and byte-lane enable helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } ahb_state_e;

    // Little-endian lane enables; only legal (aligned) sizes ever reach this.
    function automatic logic [3:0] ahb_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = 4'b0011 << addr_lo;
            default: be = 4'hF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_byte_array.sv
// Word-wide RAM with per-byte write enables, synchronous write and asynchronous read.
module ahb_sram_byte_array #(
    parameter int unsigned WORD_AW = 10
) (
    input  logic               clk,
    input  logic [WORD_AW-1:0] addr,
    input  logic [3:0]         we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    localparam int unsigned DEPTH = 1 << WORD_AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_responder.sv
// AHB-Lite SRAM responder with programmable wait states, two-cycle ERROR responses
// and a saturating error counter.
module ahb_lite_sram_responder
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        cpu_clk,
    input  logic        sys_rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [7:0]  slv_err_cnt
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    ahb_state_e        state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic        accept;
    logic        illegal;
    logic        phase_done;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, haddr[31:ADDR_W], htrans[0]};

    assign accept  = hsel & hreadyin & htrans[1];
    assign illegal = (hsize > HSIZE_WORD)
                   | ((hsize == HSIZE_HALF) & haddr[0])
                   | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        err_cnt_d  = err_cnt_q;
        phase_done = 1'b1;

        case (state_q)
            S_DATA:  phase_done = (wcnt_q == WS);
            S_ERR1:  phase_done = 1'b0;
            default: phase_done = 1'b1;
        endcase

        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (!phase_done) begin
            wcnt_d = wcnt_q + 3'd1;
        end else if (accept) begin
            addr_d  = haddr[ADDR_W-1:0];
            size_d  = hsize[1:0];
            write_d = hwrite;
            wcnt_d  = '0;
            if (illegal) begin
                state_d = S_ERR1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                state_d = S_DATA;
            end
        end else begin
            state_d = S_IDLE;
            wcnt_d  = '0;
        end
    end

    always_ff @(posedge cpu_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            write_q   <= write_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Commit only on the completing data-phase cycle; reset returns to S_IDLE, dropping it.
    assign mem_we = (state_q == S_DATA && phase_done && write_q)
                  ? ahb_byte_en(size_q, addr_q[1:0]) : 4'b0000;

    ahb_sram_byte_array #(
        .WORD_AW (ADDR_W - 2)
    ) u_array (
        .clk   (cpu_clk),
        .addr  (addr_q[ADDR_W-1:2]),
        .we    (mem_we),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    assign hreadyout   = phase_done;
    assign hresp       = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata      = (state_q == S_DATA) ? mem_rdata : '0;
    assign slv_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// Directed bench: a zero-wait and a three-wait responder share one bus.
module tb_ahb_lite_sram_responder;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        hsel0 = 1'b0, hsel3 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic [31:0] hwdata = '0;
    logic        hreadyin;

    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rdata0, rdata3;
    logic [7:0]  ecnt0, ecnt3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Unselected responders idle with hreadyout=1, so the AND is the bus HREADY.
    assign hreadyin = rdy0 & rdy3;

    ahb_lite_sram_responder #(.ADDR_W(12), .WAIT_STATES(0)) u_ws0 (
        .cpu_clk(clk), .sys_rst(sys_rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hreadyin(hreadyin), .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0),
        .slv_err_cnt(ecnt0)
    );

    ahb_lite_sram_responder #(.ADDR_W(12), .WAIT_STATES(3)) u_ws3 (
        .cpu_clk(clk), .sys_rst(sys_rst), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hreadyin(hreadyin), .hreadyout(rdy3), .hresp(resp3), .hrdata(rdata3),
        .slv_err_cnt(ecnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ap(input logic s0, input logic s3, input logic [31:0] a,
                            input logic [2:0] sz, input logic wr);
        hsel0  = s0;
        hsel3  = s3;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
        htrans = 2'd2;
    endtask

    task automatic drive_idle();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'd0;
    endtask

    // One transfer on the three-wait responder; reports wait cycles seen and final response.
    task automatic xfer3(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                         input logic [31:0] wd, output int lows,
                         output logic [31:0] rd, output logic [1:0] rs);
        drive_ap(1'b0, 1'b1, a, sz, wr);
        tick();
        drive_idle();
        hwdata = wd;
        lows = 0;
        while (!rdy3 && lows < 20) begin
            lows++;
            tick();
        end
        rd = rdata3;
        rs = resp3;
        tick();
    endtask

    initial begin
        int          lows;
        logic [31:0] rd;
        logic [1:0]  rs;

        tick();
        tick();
        check("rst_ready", {31'd0, rdy0}, 32'd1);
        check("rst_resp", {30'd0, resp0}, 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_errcnt", {24'd0, ecnt0}, 32'd0);
        sys_rst = 1'b0;
        tick();

        // Zero-wait word write followed immediately by a read of the same word.
        drive_ap(1'b1, 1'b0, 32'h010, 3'd2, 1'b1);
        tick();
        hwdata = 32'hDEADBEEF;
        drive_ap(1'b1, 1'b0, 32'h010, 3'd2, 1'b0);
        check("b2b_wr_ready", {31'd0, rdy0}, 32'd1);
        tick();
        drive_idle();
        check("b2b_rd_ready", {31'd0, rdy0}, 32'd1);
        check("b2b_rd_data", rdata0, 32'hDEADBEEF);
        tick();
        check("idle_rdata_zero", rdata0, 32'd0);

        // Byte write to lane 2 with noise on the other lanes.
        drive_ap(1'b1, 1'b0, 32'h012, 3'd0, 1'b1);
        tick();
        hwdata = 32'h11AA2233;
        drive_ap(1'b1, 1'b0, 32'h010, 3'd2, 1'b0);
        tick();
        drive_idle();
        check("byte_merge", rdata0, 32'hDEAABEEF);
        tick();

        // Clear word 0x014, then half write to upper lanes.
        drive_ap(1'b1, 1'b0, 32'h014, 3'd2, 1'b1);
        tick();
        hwdata = 32'h0;
        drive_ap(1'b1, 1'b0, 32'h016, 3'd1, 1'b1);
        tick();
        hwdata = 32'h12345678;
        drive_ap(1'b1, 1'b0, 32'h014, 3'd2, 1'b0);
        tick();
        drive_idle();
        check("half_merge", rdata0, 32'h12340000);
        tick();

        // Three-wait responder: write then read.
        xfer3(32'h020, 3'd2, 1'b1, 32'hCAFEF00D, lows, rd, rs);
        check("ws3_wr_waits", lows, 32'd3);
        xfer3(32'h020, 3'd2, 1'b0, 32'h0, lows, rd, rs);
        check("ws3_rd_waits", lows, 32'd3);
        check("ws3_rd_resp", {30'd0, rs}, 32'd0);
        check("ws3_rd_data", rd, 32'hCAFEF00D);

        // Misaligned word write gives a two-cycle ERROR and no memory change.
        drive_ap(1'b1, 1'b0, 32'h011, 3'd2, 1'b1);
        tick();
        drive_idle();
        hwdata = 32'h0;
        check("err1_ready", {31'd0, rdy0}, 32'd0);
        check("err1_resp", {30'd0, resp0}, 32'd1);
        tick();
        check("err2_ready", {31'd0, rdy0}, 32'd1);
        check("err2_resp", {30'd0, resp0}, 32'd1);
        tick();
        check("err_cnt_1", {24'd0, ecnt0}, 32'd1);
        drive_ap(1'b1, 1'b0, 32'h010, 3'd2, 1'b0);
        tick();
        drive_idle();
        check("err_no_write", rdata0, 32'hDEAABEEF);
        tick();

        // Oversized transfer.
        drive_ap(1'b1, 1'b0, 32'h010, 3'd3, 1'b0);
        tick();
        drive_idle();
        check("sz3_err1_ready", {31'd0, rdy0}, 32'd0);
        check("sz3_err1_resp", {30'd0, resp0}, 32'd1);
        tick();
        check("sz3_err2_ready", {31'd0, rdy0}, 32'd1);
        check("sz3_err2_resp", {30'd0, resp0}, 32'd1);
        tick();
        check("err_cnt_2", {24'd0, ecnt0}, 32'd2);

        // 300 back-to-back errors: the next address phase is presented during ERR2.
        for (int i = 0; i < 300; i++) begin
            drive_ap(1'b1, 1'b0, 32'h012, 3'd2, 1'b0);
            tick();
            tick();
            if (i == 99) check("err_cnt_102", {24'd0, ecnt0}, 32'd102);
        end
        drive_idle();
        tick();
        check("err_cnt_sat", {24'd0, ecnt0}, 32'd255);

        // Reset during the second wait cycle of a three-wait write.
        drive_ap(1'b0, 1'b1, 32'h020, 3'd2, 1'b1);
        tick();
        drive_idle();
        hwdata = 32'h55555555;
        tick();
        sys_rst = 1'b1;
        #1;
        check("arst_ready", {31'd0, rdy3}, 32'd1);
        check("arst_resp", {30'd0, resp3}, 32'd0);
        check("arst_rdata", rdata3, 32'd0);
        check("arst_errcnt0", {24'd0, ecnt0}, 32'd0);
        tick();
        sys_rst = 1'b0;
        tick();
        xfer3(32'h020, 3'd2, 1'b0, 32'h0, lows, rd, rs);
        check("arst_prior_data", rd, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
